crossbar_reg_stat: RTL and testbench
====================================

Name: crossbar_reg_stat

Overview:
- Parametrised successor to the router crossbar. It switches P input flits to P output ports from one-hot grants, with an optional registered output stage.
- Adds per-output SSA source selection, deterministic conflict resolution with a sticky error flag, and per-output saturating flit counters for NoC statistics.
- Sits between switch allocator and output port registers/links inside each router.

Parameters:
- P, 5, router port count (≥2).
- Fw, 36, flit width.
- SELF_LOOP_EN, "NO", "NO": an input cannot target its own output, so grant vectors are P_1=P-1 wide with the sender bit removed. "YES": P_1=P.
- SSA_EN, "YES", enables the static-straight (SS) bypass fill.
- OUT_REG, 1, 1 = flit/wr outputs registered (1-cycle latency). 0 = combinational outputs.
- STAT_W, 16, width of each per-output flit counter.
- Pw, log2(P) (min 1), derived index width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- granted_dest_port_all  in  P*P_1  per-input one-hot granted output. Input j occupies slice [j*P_1 +: P_1], sender bit removed when SELF_LOOP_EN="NO".
- flit_in_all  in  P*Fw  input flits; input j at [j*Fw +: Fw].
- ssa_flit_wr_all  in  P  per-output SS write request.
- ssa_src_sel_all  in  P*Pw  per-output SS source input index (binary).
- stat_clr  in  1  synchronous clear of all counters and error flags.
- flit_out_all  out  P*Fw  output flits; output i at [i*Fw +: Fw].
- flit_out_wr_all  out  P  output write valid.
- flit_cnt_all  out  P*STAT_W  per-output flit count.
- conflict_err  out  P  sticky: more than one input granted to output i in one cycle.

Behaviour:
- Grant expansion: each input j's P_1 grant vector is expanded to P bits, with a 0 inserted at position j when SELF_LOOP_EN="NO". Column i over all inputs gives req_i[P-1:0].
- Selection per output i:
  - If req_i ≠ 0, the source is the lowest-index set bit of req_i and wr_i=1.
  - Else if SSA_EN="YES" and ssa_flit_wr_all[i]=1, the source is ssa_src_sel_all[i] and wr_i=1.
  - Else wr_i=0 and the flit value is don't-care; the implementation drives the last selected source so the output does not toggle.
- SS request ignored: if req_i ≠ 0 while ssa_flit_wr_all[i]=1, the SS request is dropped.
- SSA disabled: with SSA_EN="NO", ssa_flit_wr_all and ssa_src_sel_all are ignored.
- Out-of-range SS source: a ssa_src_sel_all value ≥P, or equal to i when SELF_LOOP_EN="NO", is illegal. The output then gives wr_i=0 and no count increment.
- Conflict: popcount(req_i)>1 sets conflict_err[i]=1 in the next cycle. The flag holds until reset or stat_clr. Lowest-index priority still forwards exactly one flit.
- Latency:
  - OUT_REG=1: flit_out_all and flit_out_wr_all are registered; a grant in cycle N appears in cycle N+1.
  - OUT_REG=0: the same values are driven combinationally in cycle N.
- Counters: flit_cnt[i] increments by 1 on every cycle with wr_i=1, evaluated at the pre-register selection. It saturates at 2^STAT_W-1 and does not wrap.
- stat_clr: clears all counters and conflict_err on the next edge. If stat_clr and an increment occur in the same cycle, the clear wins and the counter reads 0. stat_clr does not affect the flit path.
- Reset: asynchronous on assertion, synchronous release. While reset=1: flit_out_all=0, flit_out_wr_all=0, flit_cnt_all=0, conflict_err=0. OUT_REG=0 outputs still equal the combinational path; only counters and flags reset.
- Reset mid-packet: the in-flight registered flit is discarded; no replay.
- Stall: none; the block never backpressures.

Test Plan:
- P=5, OUT_REG=1, SELF_LOOP_EN="NO": input 0 grant 4'b0001 (→ output 1), flit 0xA5 → cycle+1: flit_out[1]=0xA5, flit_out_wr_all=5'b00010, flit_cnt[1]=1.
- Inputs 1 and 3 both granted to output 0, flits 0x11/0x33 → output 0 carries 0x11, conflict_err=5'b00001 (sticky), flit_cnt[0]=1.
- No grants, SSA_EN="YES", ssa_flit_wr_all[1]=1, ssa_src_sel[1]=3, flit_in[3]=0x7E → flit_out[1]=0x7E, wr[1]=1. Then add grant input 2→output 1 with flit 0x22 → output carries 0x22, SS ignored.
- STAT_W=4: 20 consecutive writes to output 2 → flit_cnt[2]=15 held. Then stat_clr asserted concurrently with a write → count reads 0.
- SELF_LOOP_EN="YES": input 2 grant 5'b00100 → flit appears on output 2.
- Assert reset asynchronously mid-stream with OUT_REG=1 → all outputs and counters are 0 immediately. First grant after release appears one cycle later.

Source files
------------

// File: rtl/crossbar_reg_stat.sv
// Router crossbar: switches P input flits to P outputs from one-hot grants or SS bypass requests,
// with an optional output register stage and per-output saturating flit counters / sticky conflict flags.
module crossbar_reg_stat #(
  parameter int    P            = 5,
  parameter int    Fw           = 36,
  parameter string SELF_LOOP_EN = "NO",
  parameter string SSA_EN       = "YES",
  parameter int    OUT_REG      = 1,
  parameter int    STAT_W       = 16,
  localparam int   Pw           = (P > 2) ? $clog2(P) : 1,
  localparam int   P_1          = (SELF_LOOP_EN == "YES") ? P : P - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [P*P_1-1:0]      granted_dest_port_all,
  input  logic [P*Fw-1:0]       flit_in_all,
  input  logic [P-1:0]          ssa_flit_wr_all,
  input  logic [P*Pw-1:0]       ssa_src_sel_all,
  input  logic                  stat_clr,
  output logic [P*Fw-1:0]       flit_out_all,
  output logic [P-1:0]          flit_out_wr_all,
  output logic [P*STAT_W-1:0]   flit_cnt_all,
  output logic [P-1:0]          conflict_err
);

  localparam bit            SELF_LOOP = (SELF_LOOP_EN == "YES");
  localparam bit            SSA       = (SSA_EN == "YES");
  localparam logic [Pw:0]   P_LIM     = (Pw+1)'(P);
  localparam logic [P-1:0]  ONE_P     = P'(1);

  logic [P-1:0][P-1:0]      req;
  logic [P-1:0]             wr_c;
  logic [P-1:0]             conflict_c;
  logic [P-1:0][Pw-1:0]     src_c;
  logic [P-1:0][Pw-1:0]     last_src_q;
  logic [P*Fw-1:0]          flit_c;
  logic [P-1:0][STAT_W-1:0] cnt_q;
  logic [P-1:0]             conflict_q;
  logic [Pw-1:0]            ss_sel;
  logic                     ss_ok;

  // req[i][j]: input j is granted output i; the sender's own column is re-inserted as 0 when self loops are excluded
  for (genvar j = 0; j < P; j++) begin : g_in
    for (genvar k = 0; k < P; k++) begin : g_out
      if (SELF_LOOP) begin : g_full
        assign req[k][j] = granted_dest_port_all[j*P_1 + k];
      end else if (k < j) begin : g_below
        assign req[k][j] = granted_dest_port_all[j*P_1 + k];
      end else if (k > j) begin : g_above
        assign req[k][j] = granted_dest_port_all[j*P_1 + k - 1];
      end else begin : g_self
        assign req[k][j] = 1'b0;
      end
    end
  end

  always_comb begin
    wr_c       = '0;
    conflict_c = '0;
    src_c      = last_src_q;
    flit_c     = '0;
    ss_sel     = '0;
    ss_ok      = 1'b0;
    for (int i = 0; i < P; i++) begin
      conflict_c[i] = |(req[i] & (req[i] - ONE_P));
      ss_sel = ssa_src_sel_all[i*Pw +: Pw];
      ss_ok  = SSA && ssa_flit_wr_all[i] && ({1'b0, ss_sel} < P_LIM) &&
               (SELF_LOOP || (ss_sel != Pw'(i)));
      if (req[i] != '0) begin
        wr_c[i] = 1'b1;
        for (int j = P - 1; j >= 0; j--) begin
          if (req[i][j]) src_c[i] = Pw'(j);
        end
      end else if (ss_ok) begin
        wr_c[i]  = 1'b1;
        src_c[i] = ss_sel;
      end
      flit_c[i*Fw +: Fw] = flit_in_all[src_c[i]*Fw +: Fw];
    end
  end

  // Idle outputs keep pointing at their last source so the data lines stay quiet
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_src_q <= '0;
      cnt_q      <= '0;
      conflict_q <= '0;
    end else begin
      last_src_q <= src_c;
      conflict_q <= stat_clr ? '0 : (conflict_q | conflict_c);
      for (int i = 0; i < P; i++) begin
        if (stat_clr) begin
          cnt_q[i] <= '0;
        end else if (wr_c[i] && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  if (OUT_REG != 0) begin : g_reg
    logic [P*Fw-1:0] flit_q;
    logic [P-1:0]    wr_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        flit_q <= '0;
        wr_q   <= '0;
      end else begin
        flit_q <= flit_c;
        wr_q   <= wr_c;
      end
    end

    assign flit_out_all    = flit_q;
    assign flit_out_wr_all = wr_q;
  end else begin : g_comb
    assign flit_out_all    = flit_c;
    assign flit_out_wr_all = wr_c;
  end

  assign flit_cnt_all = cnt_q;
  assign conflict_err = conflict_q;

endmodule

// File: tb/tb_crossbar_reg_stat.sv
// Bench for crossbar_reg_stat: registered no-self-loop instance checked through a scoreboard,
// plus a combinational self-loop instance checked with directed values.
module tb_crossbar_reg_stat;

  localparam int P   = 5;
  localparam int FW  = 36;
  localparam int SW  = 4;
  localparam int SW1 = 16;
  localparam int PW  = 3;
  localparam int P1  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [P*P1-1:0]   grant = '0;
  logic [P*FW-1:0]   flit_in = '0;
  logic [P-1:0]      ssa_wr = '0;
  logic [P*PW-1:0]   ssa_sel = '0;
  logic              stat_clr = 1'b0;
  logic [P*FW-1:0]   flit_out;
  logic [P-1:0]      flit_wr;
  logic [P*SW-1:0]   flit_cnt;
  logic [P-1:0]      conflict;

  logic [P*P-1:0]    grant1 = '0;
  logic [P-1:0]      ssa1_wr = '0;
  logic [P*FW-1:0]   flit_out1;
  logic [P-1:0]      flit_wr1;
  logic [P*SW1-1:0]  flit_cnt1;
  logic [P-1:0]      conflict1;

  typedef struct packed {
    logic [P-1:0]    wr;
    logic [P*FW-1:0] flit;
  } exp_t;

  exp_t          sb[$];
  logic [SW-1:0] exp_cnt[P];
  logic [P-1:0]  exp_conf = '0;
  int            n_checks = 0;
  int            n_fail = 0;

  crossbar_reg_stat #(
    .P(P), .Fw(FW), .SELF_LOOP_EN("NO"), .SSA_EN("YES"), .OUT_REG(1), .STAT_W(SW)
  ) dut (
    .clk(clk), .reset(reset),
    .granted_dest_port_all(grant), .flit_in_all(flit_in),
    .ssa_flit_wr_all(ssa_wr), .ssa_src_sel_all(ssa_sel), .stat_clr(stat_clr),
    .flit_out_all(flit_out), .flit_out_wr_all(flit_wr),
    .flit_cnt_all(flit_cnt), .conflict_err(conflict)
  );

  crossbar_reg_stat #(
    .P(P), .Fw(FW), .SELF_LOOP_EN("YES"), .SSA_EN("YES"), .OUT_REG(0), .STAT_W(SW1)
  ) dut_loop (
    .clk(clk), .reset(reset),
    .granted_dest_port_all(grant1), .flit_in_all(flit_in),
    .ssa_flit_wr_all(ssa1_wr), .ssa_src_sel_all(ssa_sel), .stat_clr(stat_clr),
    .flit_out_all(flit_out1), .flit_out_wr_all(flit_wr1),
    .flit_cnt_all(flit_cnt1), .conflict_err(conflict1)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [P*FW-1:0] obs, input logic [P*FW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Input-centric reference: walk inputs in ascending order, first claimant of an output wins
  function automatic void model(output logic [P-1:0] wr, output logic [P*FW-1:0] fo,
                                output logic [P-1:0] conf);
    int o;
    int s;
    wr = '0;
    fo = '0;
    conf = '0;
    for (int j = 0; j < P; j++) begin
      for (int b = 0; b < P1; b++) begin
        if (grant[j*P1 + b]) begin
          o = (b < j) ? b : b + 1;
          if (wr[o]) conf[o] = 1'b1;
          else begin
            wr[o] = 1'b1;
            fo[o*FW +: FW] = flit_in[j*FW +: FW];
          end
        end
      end
    end
    for (int k = 0; k < P; k++) begin
      s = int'(ssa_sel[k*PW +: PW]);
      if (!wr[k] && ssa_wr[k] && s < P && s != k) begin
        wr[k] = 1'b1;
        fo[k*FW +: FW] = flit_in[s*FW +: FW];
      end
    end
  endfunction

  task automatic apply_stimulus();
    exp_t e;
    logic [P-1:0] conf;
    model(e.wr, e.flit, conf);
    sb.push_back(e);
    for (int o = 0; o < P; o++) begin
      if (stat_clr) exp_cnt[o] = '0;
      else if (e.wr[o] && exp_cnt[o] != 4'hF) exp_cnt[o] = exp_cnt[o] + 1'b1;
    end
    exp_conf = stat_clr ? '0 : (exp_conf | conf);
  endtask

  task automatic check_output();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check_value("flit_out_wr_all", flit_wr, e.wr);
      for (int o = 0; o < P; o++) begin
        if (e.wr[o]) check_value($sformatf("flit_out[%0d]", o), flit_out[o*FW +: FW], e.flit[o*FW +: FW]);
      end
    end
    for (int o = 0; o < P; o++) begin
      check_value($sformatf("flit_cnt[%0d]", o), flit_cnt[o*SW +: SW], exp_cnt[o]);
    end
    check_value("conflict_err", conflict, exp_conf);
  endtask

  task automatic clear_inputs();
    grant = '0;
    ssa_wr = '0;
    ssa_sel = '0;
    stat_clr = 1'b0;
  endtask

  initial begin
    for (int o = 0; o < P; o++) exp_cnt[o] = '0;
    #1;
    check_value("reset flit_out", flit_out, '0);
    check_value("reset flit_wr", flit_wr, '0);
    check_value("reset flit_cnt", flit_cnt, '0);
    check_value("reset conflict", conflict, '0);
    check_value("reset loop cnt", flit_cnt1, '0);
    @(negedge clk);
    reset = 1'b0;

    // Input 0 to output 1
    clear_inputs();
    grant[0*P1 +: P1] = 4'b0001;
    flit_in[0*FW +: FW] = 36'hA5;
    apply_stimulus();
    check_output();
    check_value("single flit_wr", flit_wr, 5'b00010);

    // Inputs 1 and 3 both to output 0
    clear_inputs();
    grant[1*P1 +: P1] = 4'b0001;
    grant[3*P1 +: P1] = 4'b0001;
    flit_in[1*FW +: FW] = 36'h11;
    flit_in[3*FW +: FW] = 36'h33;
    apply_stimulus();
    check_output();
    check_value("conflict out0", flit_out[0 +: FW], 36'h11);
    check_value("conflict flag", conflict, 5'b00001);

    clear_inputs();
    apply_stimulus();
    check_output();
    check_value("conflict sticky", conflict, 5'b00001);

    // SS bypass: output 1 sourced from input 3
    clear_inputs();
    ssa_wr[1] = 1'b1;
    ssa_sel[1*PW +: PW] = 3'd3;
    flit_in[3*FW +: FW] = 36'h7E;
    apply_stimulus();
    check_output();
    check_value("ss out1", flit_out[1*FW +: FW], 36'h7E);

    // Grant overrides SS on the same output
    grant[2*P1 +: P1] = 4'b0010;
    flit_in[2*FW +: FW] = 36'h22;
    apply_stimulus();
    check_output();
    check_value("ss overridden out1", flit_out[1*FW +: FW], 36'h22);

    // Illegal SS sources: self index and out-of-range index
    clear_inputs();
    ssa_wr = 5'b01100;
    ssa_sel[2*PW +: PW] = 3'd2;
    ssa_sel[3*PW +: PW] = 3'd7;
    apply_stimulus();
    check_output();
    check_value("illegal ss wr", flit_wr, '0);

    // Self-loop combinational instance
    clear_inputs();
    grant1[2*P +: P] = 5'b00100;
    flit_in[2*FW +: FW] = 36'h9_8765_4321;
    #1;
    check_value("loop wr comb", flit_wr1, 5'b00100);
    check_value("loop out2 comb", flit_out1[2*FW +: FW], 36'h9_8765_4321);
    apply_stimulus();
    check_output();
    check_value("loop cnt2", flit_cnt1[2*SW1 +: SW1], 16'd1);
    grant1 = '0;

    for (int s = 0; s < 8; s++) begin
      for (int j = 0; j < P; j++) begin
        grant[j*P1 +: P1] = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'(1 << $urandom_range(0, 3));
        flit_in[j*FW +: FW] = 36'({$urandom(), $urandom()});
      end
      ssa_wr = 5'($urandom());
      ssa_sel = 15'($urandom());
      apply_stimulus();
      check_output();
    end

    // Clear with traffic present
    stat_clr = 1'b1;
    apply_stimulus();
    check_output();
    check_value("clr conflict", conflict, '0);

    // Saturation on output 2
    clear_inputs();
    grant[0*P1 +: P1] = 4'b0010;
    for (int s = 0; s < 20; s++) begin
      flit_in[0 +: FW] = 36'(s + 100);
      apply_stimulus();
      check_output();
    end
    check_value("saturated cnt2", flit_cnt[2*SW +: SW], 4'd15);
    stat_clr = 1'b1;
    apply_stimulus();
    check_output();
    check_value("clr beats inc", flit_cnt[2*SW +: SW], 4'd0);

    // Asynchronous reset between edges with a flit in flight
    clear_inputs();
    grant[1*P1 +: P1] = 4'b0100;
    flit_in[1*FW +: FW] = 36'h5A;
    apply_stimulus();
    #2;
    reset = 1'b1;
    grant1[0 +: P] = 5'b01000;
    flit_in[0 +: FW] = 36'hC3;
    #1;
    check_value("async rst flit_out", flit_out, '0);
    check_value("async rst flit_wr", flit_wr, '0);
    check_value("async rst cnt", flit_cnt, '0);
    check_value("async rst conflict", conflict, '0);
    check_value("rst loop wr comb", flit_wr1, 5'b01000);
    check_value("rst loop out3 comb", flit_out1[3*FW +: FW], 36'hC3);
    check_value("rst loop cnt", flit_cnt1, '0);
    sb.delete();
    for (int o = 0; o < P; o++) exp_cnt[o] = '0;
    exp_conf = '0;
    @(negedge clk);
    reset = 1'b0;
    grant1 = '0;
    clear_inputs();
    grant[3*P1 +: P1] = 4'b1000;
    flit_in[3*FW +: FW] = 36'hF_0F0F_0F0F;
    apply_stimulus();
    #1;
    check_value("post rst not yet", flit_wr, '0);
    check_output();
    check_value("post rst out4", flit_out[4*FW +: FW], 36'hF_0F0F_0F0F);

    clear_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
